serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around one single-bit full-adder cell and a carry flip-flop.
//   It accepts a start pulse with two operands and a carry-in, then feeds one bit pair per clock,
//   LSB first, through the 1-bit full adder. Result S/Cout is presented with a one-cycle done

---
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_adder.sv | 83 ++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a serial_adder and its client
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;

    modport master (
        output start, A, B, Cin,
        input  busy, done, S, Cout
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, S, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell plus carry flop, LSB first
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    // The single full-adder cell shared by every bit position.
    always_comb begin
        fa_s = a_sh[0] ^ b_sh[0] ^ carry;
        fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.S    <= '0;
            bus.Cout <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.A;
                        b_sh     <= bus.B;
                        carry    <= bus.Cin;
                        cnt      <= '0;
                        bus.S    <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so bit 0 lands at S[0] after WIDTH shifts.
                    bus.S <= {fa_s, bus.S[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.Cout <= fa_c;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and held-start checks of serial_adder at WIDTH=8
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    serial_adder_if #(.WIDTH(8)) bus ();

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_s;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          output logic [7:0] s, output logic co,
                          output int lat, output int busy_cyc);
        bit got;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.start = 1'b1;
        lat = 0;
        busy_cyc = 0;
        got = 0;
        s = '0;
        co = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (i == 0) bus.start = 1'b0;
            lat++;
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                got = 1;
                s = bus.S;
                co = bus.Cout;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [7:0] s;
        logic       co;
        int         lat;
        int         bcyc;
        int         ndone;
        int         last_cyc;
        bit         got;
        logic [7:0] cur_a;
        logic [7:0] cur_b;
        logic       cur_cin;
        logic [8:0] exp9;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[3] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        vecs[4] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
        vecs[5] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[9] = '{8'h01, 8'h00, 1'b1, 8'h02, 1'b0};

        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_s", 32'(bus.S), 32'd0);
        check("rst_cout", 32'(bus.Cout), 32'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].cin, s, co, lat, bcyc);
            check($sformatf("vec%0d_s", v), 32'(s), 32'(vecs[v].exp_s));
            check($sformatf("vec%0d_cout", v), 32'(co), 32'(vecs[v].exp_cout));
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd9);
            check($sformatf("vec%0d_busy_cycles", v), 32'(bcyc), 32'd9);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_s_hold", v), 32'(bus.S), 32'(vecs[v].exp_s));
            check($sformatf("vec%0d_cout_hold", v), 32'(bus.Cout), 32'(vecs[v].exp_cout));
        end

        // Operand changes and start pulses while busy must not disturb the running add.
        @(negedge clk);
        bus.A = 8'h12;
        bus.B = 8'h34;
        bus.Cin = 1'b0;
        bus.start = 1'b1;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                check("t4_s", 32'(bus.S), 32'h46);
                check("t4_cout", 32'(bus.Cout), 32'd0);
            end
            bus.A = 8'($urandom);
            bus.B = 8'($urandom);
            bus.Cin = 1'($urandom);
            bus.start = 1'b1;
        end
        check("t4_done_seen", 32'(got), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("t4_no_second_done", 32'(ndone), 32'd0);
        check("t4_idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        bus.A = 8'h5A;
        bus.B = 8'hA5;
        bus.Cin = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_s", 32'(bus.S), 32'd0);
        check("t5_rst_cout", 32'(bus.Cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("t5_no_done", 32'(ndone), 32'd0);
        run_op(8'hC8, 8'h64, 1'b0, s, co, lat, bcyc);
        check("t5_s", 32'(s), 32'h2C);
        check("t5_cout", 32'(co), 32'd1);

        // start held high: back-to-back operations against an arithmetic model.
        cur_a = 8'($urandom);
        cur_b = 8'($urandom);
        cur_cin = 1'($urandom);
        @(negedge clk);
        bus.A = cur_a;
        bus.B = cur_b;
        bus.Cin = cur_cin;
        bus.start = 1'b1;
        last_cyc = 0;
        for (int n = 0; n < 200; n++) begin
            got = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (bus.done) got = 1;
            end
            if (!got) begin
                check("t6_done_timeout", 32'd0, 32'd1);
                break;
            end
            exp9 = {1'b0, cur_a} + {1'b0, cur_b} + {8'd0, cur_cin};
            check($sformatf("t6_%0d_s", n), 32'(bus.S), 32'(exp9[7:0]));
            check($sformatf("t6_%0d_cout", n), 32'(bus.Cout), 32'(exp9[8]));
            if (n > 0) check($sformatf("t6_%0d_spacing", n), 32'(cyc - last_cyc), 32'd10);
            last_cyc = cyc;
            cur_a = 8'($urandom);
            cur_b = 8'($urandom);
            cur_cin = 1'($urandom);
            bus.A = cur_a;
            bus.B = cur_b;
            bus.Cin = cur_cin;
        end
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
